z16_instr_loader: RTL and testbench



---
 rtl/z16_instr_loader.sv | 194 +++++++++++++++++++
 tb/tb_z16_instr_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/z16_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : z16_instr_loader
// Brief    : Framed byte-stream loader for the Z16 instruction RAM. Parses
//            SYNC / LEN_LO / LEN_HI / N x {lo, hi} / CHK frames, writes each
//            little-endian 16-bit word to the RAM write port, holds the CPU
//            during a load and reports done / error.
// Revision : 1.0 - initial release
// ============================================================================
module z16_instr_loader #(
    parameter int          DEPTH_WORDS = 16,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_byte,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_we,
    output logic [15:0] o_waddr,
    output logic [15:0] o_wdata,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic        o_err
);

    // One extra bit so the index can reach DEPTH_WORDS without wrapping.
    localparam int          c_IDX_W = $clog2(DEPTH_WORDS) + 1;
    localparam logic [15:0] c_DEPTH = 16'(DEPTH_WORDS);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LEN_LO = 4'd1,
        S_LEN_HI = 4'd2,
        S_D_LO   = 4'd3,
        S_D_HI   = 4'd4,
        S_WRITE  = 4'd5,
        S_CHK    = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    state_t               state_q,    state_d;
    logic [7:0]           len_lo_q,   len_lo_d;
    logic [15:0]          len_q,      len_d;
    logic [7:0]           lo_q,       lo_d;
    logic [7:0]           chk_q,      chk_d;
    logic [c_IDX_W-1:0]   idx_q,      idx_d;
    logic                 we_q,       we_d;
    logic [15:0]          waddr_q,    waddr_d;
    logic [15:0]          wdata_q,    wdata_d;
    logic                 hold_q,     hold_d;
    logic                 done_q,     done_d;
    logic                 err_q,      err_d;

    logic                 w_accept;
    logic [15:0]          w_len;
    logic [c_IDX_W-1:0]   w_idx_inc;

    assign o_ready    = (state_q != S_WRITE);
    assign w_accept   = i_valid && o_ready;
    assign w_len      = {i_byte, len_lo_q};
    assign w_idx_inc  = idx_q + 1'b1;

    assign o_we       = we_q;
    assign o_waddr    = waddr_q;
    assign o_wdata    = wdata_q;
    assign o_cpu_hold = hold_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

    // Next-state and datapath: frame parser, write-port staging, status flags.
    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        lo_d     = lo_q;
        chk_d    = chk_q;
        idx_d    = idx_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        done_d   = done_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept && (i_byte == SYNC_BYTE)) begin
                    state_d = S_LEN_LO;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    chk_d   = 8'd0;
                    idx_d   = '0;
                    hold_d  = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    len_lo_d = i_byte;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    len_d = w_len;
                    if (w_len > c_DEPTH) begin
                        state_d = S_ERR;
                    end else if (w_len == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_D_LO;
                    end
                end
            end
            S_D_LO: begin
                if (w_accept) begin
                    lo_d    = i_byte;
                    chk_d   = chk_q + i_byte;
                    state_d = S_D_HI;
                end
            end
            S_D_HI: begin
                // Write port is staged here so o_we is high during WRITE.
                if (w_accept) begin
                    chk_d   = chk_q + i_byte;
                    we_d    = 1'b1;
                    waddr_d = 16'(idx_q) << 1;
                    wdata_d = {i_byte, lo_q};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d = w_idx_inc;
                if (16'(w_idx_inc) == len_q) begin
                    state_d = S_CHK;
                end else begin
                    state_d = S_D_LO;
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    state_d = (i_byte == chk_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                hold_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err_d   = 1'b1;
                hold_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            len_lo_q <= 8'd0;
            len_q    <= 16'd0;
            lo_q     <= 8'd0;
            chk_q    <= 8'd0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= 16'd0;
            wdata_q  <= 16'd0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            lo_q     <= lo_d;
            chk_q    <= chk_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_z16_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_z16_instr_loader
// Brief    : Self-checking bench for z16_instr_loader. Frame vectors with
//            expected writes and status; expected writes go into a queue and
//            are popped by a monitor whenever o_we pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_z16_instr_loader;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_byte;
    logic        i_valid;
    logic        o_ready;
    logic        o_we;
    logic [15:0] o_waddr;
    logic [15:0] o_wdata;
    logic        o_cpu_hold;
    logic        o_done;
    logic        o_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];   // {addr, data}

    typedef struct {
        logic [7:0]  b  [12];
        int          nb;      // bytes in stream
        int          start;   // position of the sync byte
        int          ndw;     // data words actually written
        logic [15:0] wa [2];
        logic [15:0] wd [2];
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs [5];

    z16_instr_loader #(
        .DEPTH_WORDS (16),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_byte     (i_byte),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_we       (o_we),
        .o_waddr    (o_waddr),
        .o_wdata    (o_wdata),
        .o_cpu_hold (o_cpu_hold),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write,
    // and the loader must not be accepting bytes in that cycle.
    always @(negedge i_clk) begin
        if (o_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL we_unexpected actual=%h required=none", {o_waddr, o_wdata});
            end else begin
                chk("we_addr_data", {o_waddr, o_wdata}, exp_q.pop_front());
            end
            chk("ready_in_write", {31'd0, o_ready}, 32'd0);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int guard = 0;
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gap) begin
            i_valid = 1'b0;
            i_byte  = 8'($urandom);
            @(negedge i_clk);
        end
        i_byte  = b;
        i_valid = 1'b1;
        while (o_ready !== 1'b1 && guard < 10) begin
            @(negedge i_clk);
            guard++;
        end
        if (guard >= 10) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=%b required=1", o_ready);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    // Drive one frame vector; checks write latency, status latency and flags.
    task automatic run_vec(input vec_t v, input int id);
        int rel;
        for (int k = 0; k < v.ndw; k++) exp_q.push_back({v.wa[k], v.wd[k]});
        for (int i = 0; i < v.nb; i++) begin
            send_byte(v.b[i], 0);
            rel = i - v.start - 3;
            if (rel >= 0 && rel < 2 * v.ndw && (rel % 2) == 1)
                chk($sformatf("v%0d_we_latency", id), {31'd0, o_we}, 32'd1);
        end
        chk($sformatf("v%0d_hold_before_status", id), {29'd0, o_cpu_hold, o_done, o_err}, 32'b100);
        @(negedge i_clk);
        chk($sformatf("v%0d_status", id), {29'd0, o_cpu_hold, o_done, o_err},
            {29'd0, 1'b0, v.done, v.err});
        chk($sformatf("v%0d_writes_seen", id), exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sum;

        vecs[0] = '{b: '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h19, 8'h01, 8'h2A, 8'h00, 8'h00, 8'h00, 8'h00},
                    nb: 8, start: 0, ndw: 2, wa: '{16'h0000, 16'h0002}, wd: '{16'h0010, 16'h0119},
                    done: 1'b1, err: 1'b0};
        vecs[1] = '{b: '{8'hA5, 8'h01, 8'h00, 8'h19, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nb: 6, start: 0, ndw: 1, wa: '{16'h0000, 16'h0000}, wd: '{16'h0119, 16'h0000},
                    done: 1'b0, err: 1'b1};
        vecs[2] = '{b: '{8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nb: 3, start: 0, ndw: 0, wa: '{16'h0000, 16'h0000}, wd: '{16'h0000, 16'h0000},
                    done: 1'b0, err: 1'b1};
        vecs[3] = '{b: '{8'hA5, 8'h01, 8'h00, 8'h40, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nb: 6, start: 0, ndw: 1, wa: '{16'h0000, 16'h0000}, wd: '{16'h0040, 16'h0000},
                    done: 1'b1, err: 1'b0};
        vecs[4] = '{b: '{8'h33, 8'h77, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nb: 6, start: 2, ndw: 0, wa: '{16'h0000, 16'h0000}, wd: '{16'h0000, 16'h0000},
                    done: 1'b1, err: 1'b0};

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_byte  = 8'h00;
        repeat (3) @(negedge i_clk);
        chk("rst_we",    {31'd0, o_we},       32'd0);
        chk("rst_waddr", {16'd0, o_waddr},    32'd0);
        chk("rst_wdata", {16'd0, o_wdata},    32'd0);
        chk("rst_hold",  {31'd0, o_cpu_hold}, 32'd0);
        chk("rst_done",  {31'd0, o_done},     32'd0);
        chk("rst_err",   {31'd0, o_err},      32'd0);
        chk("rst_ready", {31'd0, o_ready},    32'd1);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Table-driven frames.
        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v], v);
            repeat (2) @(negedge i_clk);
        end

        // Full depth with random stalls: word k = k at index k.
        sum = 8'd0;
        send_byte(8'hA5, 2);
        chk("full_hold_on_sync", {31'd0, o_cpu_hold}, 32'd1);
        send_byte(8'h10, 2);
        send_byte(8'h00, 2);
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back({16'(k << 1), 16'(k)});
            sum = sum + 8'(k);
            send_byte(8'(k), 2);
            send_byte(8'h00, 2);
        end
        chk("full_sum_const", {24'd0, sum}, 32'h78);
        send_byte(sum, 2);
        @(negedge i_clk);
        chk("full_status", {29'd0, o_cpu_hold, o_done, o_err}, 32'b010);
        chk("full_writes_seen", exp_q.size(), 0);
        chk("full_last_addr", {16'd0, o_waddr}, 32'h001E);
        repeat (2) @(negedge i_clk);

        // Reset after the lo byte of word 1.
        exp_q.push_back({16'h0000, 16'hBEEF});
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'h12, 0);
        chk("mid_hold", {31'd0, o_cpu_hold}, 32'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("mid_rst_outs", {o_waddr, o_wdata}, 32'd0);
        chk("mid_rst_flags", {27'd0, o_we, o_cpu_hold, o_done, o_err, o_ready}, 32'b00001);
        repeat (5) @(negedge i_clk);
        chk("mid_writes_seen", exp_q.size(), 0);
        run_vec(vecs[0], 5);
        repeat (2) @(negedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
